snake_engine: RTL and testbench
===============================

Name: snake_engine

Overview:
- Parametrised snake-game core that replaces the fixed-grid control/datapath pair.
- Holds the snake body in a circular buffer of up to MAX_LEN segments.
- On each movement tick it advances the head, checks for wall and self-collision, and grows on food.
- Emits erase/draw pixel requests over a valid/ready stream that feeds the VGA adapter's plot/x/y/colour inputs.

Parameters:
- X_W, 8: x coordinate width.
- Y_W, 7: y coordinate width.
- GRID_W, 160: playfield width in cells; legal x is 0..GRID_W-1.
- GRID_H, 120: playfield height in cells; legal y is 0..GRID_H-1.
- MAX_LEN, 64: body buffer depth; must be a power of two, at least 2.
- START_X, 10: head x after reset.
- START_Y, 60: head y after reset.
- HEAD_COLOUR, 3'b010: colour used to draw the head pixel.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- tick  in  1  one-cycle movement strobe from the rate divider
- dir_req  in  2  requested direction: 0 left, 1 right, 2 up, 3 down
- food_x  in  X_W  food cell x
- food_y  in  Y_W  food cell y
- food_valid  in  1  food position is live
- pix_ready  in  1  pixel sink accepts this cycle
- pix_valid  out  1  pixel request pending
- pix_x  out  X_W  pixel x
- pix_y  out  Y_W  pixel y
- pix_colour  out  3  pixel colour
- ate  out  1  one-cycle pulse: food consumed, food generator must re-place
- dead  out  1  game over, sticky
- busy  out  1  step in progress
- length  out  $clog2(MAX_LEN)+1  current segment count

Behaviour:
- Reset: reset resetn, asynchronous, active-low; clock clk.
  - Register values: state=IDLE, head=(START_X,START_Y), buffer[0]=head, length=1, cur_dir=RIGHT.
  - Output values: pix_valid=0, pix_x=0, pix_y=0, pix_colour=0, ate=0, dead=0, busy=0.
- States: IDLE, STEP, SCAN, ERASE, DRAW, DEAD. busy=1 in STEP, SCAN, ERASE and DRAW.
- IDLE:
  - tick=1 goes to STEP and latches cur_dir<=dir_req, unless dir_req is the exact reverse of cur_dir (then cur_dir is unchanged).
  - tick in any other state is dropped, not queued.
- STEP (1 cycle):
  - Compute nxt = head moved one cell in cur_dir.
  - Out of range (x<0, x>=GRID_W, y<0, y>=GRID_H) goes to DEAD.
  - Otherwise grow = food_valid && nxt==(food_x,food_y); grow is forced 0 when length==MAX_LEN. Then go to SCAN.
- SCAN:
  - Compares nxt against one body segment per cycle, from head backwards.
  - Count is length entries if grow, else length-1 (the tail vacates this step).
  - Count 0 skips SCAN in 0 cycles.
  - Any match goes to DEAD. Otherwise go to ERASE if !grow, else DRAW.
- ERASE:
  - pix_valid=1 with the tail cell, colour 3'b000.
  - Hold until pix_valid && pix_ready, then go to DRAW.
- DRAW:
  - pix_valid=1 with nxt and HEAD_COLOUR.
  - On handshake:
    - write nxt at head_ptr+1 (mod MAX_LEN); head<=nxt.
    - if !grow, tail_ptr advances.
    - if grow: length+1 and ate=1 for that single cycle.
    - go to IDLE.
- Handshake: pix_x, pix_y and pix_colour are stable while pix_valid=1 && !pix_ready. pix_valid drops the cycle after acceptance.
- DEAD: dead=1, pix_valid=0. Exit only by reset. Buffer contents frozen.
- Step latency with pix_ready tied to 1: 1 (STEP) + scan count + 1 (ERASE, if !grow) + 1 (DRAW) cycles.
- Pointers are modulo MAX_LEN. length never exceeds MAX_LEN; growth at MAX_LEN behaves as a normal move.
- Reset asserted mid-step aborts immediately: pix_valid=0 and all reset values apply.

Optional Feature:
- Macro: SNAKE_WALL_WRAP_EN.
- Defined: STEP wraps coordinates instead of killing:
  - x=-1 becomes GRID_W-1; x=GRID_W becomes 0.
  - y=-1 becomes GRID_H-1; y=GRID_H becomes 0.
  - Wall death is removed; self-collision still kills.
- Undefined: leaving the grid goes to DEAD as above.

Test Plan:
- Reset, one tick, dir_req=1, pix_ready=1.
  - Required: ERASE (10,60,000) then DRAW (11,60,010).
  - ate=0, length=1, busy back to 0 after 3 cycles.
- Head at (11,60) moving right, dir_req=0 on tick → reversal rejected; head moves to (12,60).
- Food (12,60), food_valid=1, head (11,60) moving right, tick.
  - Required: no ERASE; DRAW (12,60); ate one-cycle pulse; length=2.
- pix_ready held 0 for 5 cycles during ERASE.
  - Required: pix_valid stays 1 with stable coordinates; a tick arriving meanwhile is ignored; the step completes after pix_ready=1.
- Head (159,60) moving right, tick.
  - Without macro: dead=1, no pixel emitted.
  - With SNAKE_WALL_WRAP_EN: DRAW (0,60).
- Grow to length 5, steer up, left, down into own body.
  - Required: dead=1 after SCAN; later ticks produce no pix_valid; reset restores length=1, head (10,60).

Source files
------------

// File: rtl/snake_engine_if.sv
// Pixel request stream from snake_engine to the VGA adapter plot/x/y/colour inputs.
interface snake_engine_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7
);
  logic           pix_valid;
  logic           pix_ready;
  logic [X_W-1:0] pix_x;
  logic [Y_W-1:0] pix_y;
  logic [2:0]     pix_colour;

  modport master (output pix_valid, pix_x, pix_y, pix_colour, input pix_ready);
  modport slave  (input pix_valid, pix_x, pix_y, pix_colour, output pix_ready);
endinterface

// File: rtl/snake_engine.sv
// Snake-game core: circular body buffer, per-tick move/collision/grow, erase/draw pixel stream.
// Optional SNAKE_WALL_WRAP_EN makes the head wrap around the grid edges instead of dying.
module snake_engine #(
  parameter int         X_W         = 8,
  parameter int         Y_W         = 7,
  parameter int         GRID_W      = 160,
  parameter int         GRID_H      = 120,
  parameter int         MAX_LEN     = 64,
  parameter int         START_X     = 10,
  parameter int         START_Y     = 60,
  parameter logic [2:0] HEAD_COLOUR = 3'b010
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      tick,
  input  logic [1:0]                dir_req,
  input  logic [X_W-1:0]            food_x,
  input  logic [Y_W-1:0]            food_y,
  input  logic                      food_valid,
  snake_engine_if.master            pix,
  output logic                      ate,
  output logic                      dead,
  output logic                      busy,
  output logic [$clog2(MAX_LEN):0]  length
);
  localparam int PW = $clog2(MAX_LEN);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {LEFT, RIGHT, UP, DOWN} dir_t;
  typedef enum logic [2:0] {IDLE, STEP, SCAN, ERASE, DRAW, DEAD} state_t;

  state_t         state, state_nx;
  dir_t           cur_dir;
  logic [X_W-1:0] body_x [MAX_LEN];
  logic [Y_W-1:0] body_y [MAX_LEN];
  logic [PW-1:0]  head_ptr, tail_ptr, scan_ptr;
  logic [LW-1:0]  scan_cnt;
  logic [X_W-1:0] head_x, nxt_x, mv_x;
  logic [Y_W-1:0] head_y, nxt_y, mv_y;
  logic           grow, edge_hit, wall, step_grow, hit_body;
  logic [LW-1:0]  step_cnt;

  // Head is always on-grid, so leaving the grid is detected from the edge cell alone.
  always_comb begin
    mv_x     = head_x;
    mv_y     = head_y;
    edge_hit = 1'b0;
    unique case (cur_dir)
      LEFT:  if (head_x == '0) begin edge_hit = 1'b1; mv_x = X_W'(GRID_W - 1); end
             else mv_x = head_x - X_W'(1);
      RIGHT: if (head_x == X_W'(GRID_W - 1)) begin edge_hit = 1'b1; mv_x = '0; end
             else mv_x = head_x + X_W'(1);
      UP:    if (head_y == '0) begin edge_hit = 1'b1; mv_y = Y_W'(GRID_H - 1); end
             else mv_y = head_y - Y_W'(1);
      DOWN:  if (head_y == Y_W'(GRID_H - 1)) begin edge_hit = 1'b1; mv_y = '0; end
             else mv_y = head_y + Y_W'(1);
    endcase
  end

`ifdef SNAKE_WALL_WRAP_EN
  assign wall = 1'b0;
`else
  assign wall = edge_hit;
`endif

  assign step_grow = food_valid && (mv_x == food_x) && (mv_y == food_y) &&
                     (length != LW'(MAX_LEN));
  assign step_cnt  = step_grow ? length : length - LW'(1);
  assign hit_body  = (body_x[scan_ptr] == nxt_x) && (body_y[scan_ptr] == nxt_y);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (tick) state_nx = STEP;
      STEP:  if (wall) state_nx = DEAD;
             else if (step_cnt == '0) state_nx = step_grow ? DRAW : ERASE;
             else state_nx = SCAN;
      SCAN:  if (hit_body) state_nx = DEAD;
             else if (scan_cnt == LW'(1)) state_nx = grow ? DRAW : ERASE;
      ERASE: if (pix.pix_ready) state_nx = DRAW;
      DRAW:  if (pix.pix_ready) state_nx = IDLE;
      DEAD:  state_nx = DEAD;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    pix.pix_valid  = 1'b0;
    pix.pix_x      = '0;
    pix.pix_y      = '0;
    pix.pix_colour = '0;
    if (state == ERASE) begin
      pix.pix_valid = 1'b1;
      pix.pix_x     = body_x[tail_ptr];
      pix.pix_y     = body_y[tail_ptr];
    end else if (state == DRAW) begin
      pix.pix_valid  = 1'b1;
      pix.pix_x      = nxt_x;
      pix.pix_y      = nxt_y;
      pix.pix_colour = HEAD_COLOUR;
    end
  end

  assign busy = state inside {STEP, SCAN, ERASE, DRAW};
  assign dead = (state == DEAD);
  assign ate  = (state == DRAW) && pix.pix_ready && grow;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cur_dir  <= RIGHT;
      head_x   <= X_W'(START_X);
      head_y   <= Y_W'(START_Y);
      nxt_x    <= '0;
      nxt_y    <= '0;
      grow     <= 1'b0;
      head_ptr <= '0;
      tail_ptr <= '0;
      scan_ptr <= '0;
      scan_cnt <= '0;
      length   <= LW'(1);
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        body_x[i] <= '0;
        body_y[i] <= '0;
      end
      body_x[0] <= X_W'(START_X);
      body_y[0] <= Y_W'(START_Y);
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: if (tick && (dir_t'(dir_req) != dir_t'(cur_dir ^ 2'b01)))
                cur_dir <= dir_t'(dir_req);
        STEP: begin
          nxt_x    <= mv_x;
          nxt_y    <= mv_y;
          grow     <= step_grow;
          scan_ptr <= head_ptr;
          scan_cnt <= step_cnt;
        end
        SCAN: begin
          scan_ptr <= scan_ptr - PW'(1);
          scan_cnt <= scan_cnt - LW'(1);
        end
        DRAW: if (pix.pix_ready) begin
          head_ptr                  <= head_ptr + PW'(1);
          body_x[head_ptr + PW'(1)] <= nxt_x;
          body_y[head_ptr + PW'(1)] <= nxt_y;
          head_x                    <= nxt_x;
          head_y                    <= nxt_y;
          if (grow) length   <= length + LW'(1);
          else      tail_ptr <= tail_ptr + PW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_snake_engine.sv
// Self-checking bench for snake_engine; reference model keeps the body as a queue of cells.
`timescale 1ns/1ps
module tb_snake_engine;
  localparam int X_W = 8, Y_W = 7, GW = 160, GH = 120, ML = 64;
  localparam int LW = $clog2(ML) + 1;

  logic           clk = 1'b0, resetn = 1'b0, tick = 1'b0, food_valid = 1'b0;
  logic [1:0]     dir_req = '0;
  logic [X_W-1:0] food_x = '0;
  logic [Y_W-1:0] food_y = '0;
  logic           ate, dead, busy;
  logic [LW-1:0]  length;

  snake_engine_if #(.X_W(X_W), .Y_W(Y_W)) pix ();

  snake_engine #(
    .X_W(X_W), .Y_W(Y_W), .GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML),
    .START_X(10), .START_Y(60), .HEAD_COLOUR(3'b010)
  ) dut (
    .clk(clk), .resetn(resetn), .tick(tick), .dir_req(dir_req),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
    .pix(pix), .ate(ate), .dead(dead), .busy(busy), .length(length)
  );

  always #5 clk = ~clk;

  typedef logic [X_W+Y_W+2:0] ev_t;  // {x, y, colour}
  int  passed = 0, total = 0;
  int  bx[$], by[$];
  int  m_dir;
  bit  m_dead;
  ev_t got_q[$], exp_q[$];
  int  ate_cnt = 0, stall_bad = 0, valid_cnt = 0;
  bit  stall_seen = 0;
  ev_t stall_ev;

  // Records accepted pixels, ate pulses and any change of a stalled request.
  always @(negedge clk) begin
    if (!resetn) stall_seen = 0;
    else begin
      if (ate) ate_cnt++;
      if (pix.pix_valid) begin
        valid_cnt++;
        if (stall_seen && {pix.pix_x, pix.pix_y, pix.pix_colour} !== stall_ev) stall_bad++;
        if (pix.pix_ready) begin
          got_q.push_back({pix.pix_x, pix.pix_y, pix.pix_colour});
          stall_seen = 0;
        end else begin
          stall_seen = 1;
          stall_ev   = {pix.pix_x, pix.pix_y, pix.pix_colour};
        end
      end else stall_seen = 0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  task automatic model_reset();
    bx.delete(); by.delete();
    bx.push_back(10); by.push_back(60);
    m_dir = 1; m_dead = 0;
  endtask

  // One movement step from the game rules; returns expected growth and busy cycles.
  task automatic model_step(input int d, input bit fv, input int fx, input int fy,
                            output bit g, output int lat);
    int nx, ny, span;
    bit off, hit;
    g = 0; lat = 0; hit = 0;
    if (m_dead) return;
    if (!((d == 0 && m_dir == 1) || (d == 1 && m_dir == 0) ||
          (d == 2 && m_dir == 3) || (d == 3 && m_dir == 2))) m_dir = d;
    nx = bx[0]; ny = by[0];
    case (m_dir)
      0: nx = nx - 1;
      1: nx = nx + 1;
      2: ny = ny - 1;
      default: ny = ny + 1;
    endcase
    off = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
`ifdef SNAKE_WALL_WRAP_EN
    nx = (nx + GW) % GW; ny = (ny + GH) % GH; off = 0;
`endif
    lat = 1;
    if (off) begin m_dead = 1; return; end
    g = fv && (nx == fx) && (ny == fy) && (bx.size() < ML);
    span = g ? bx.size() : bx.size() - 1;
    for (int i = 0; i < span; i++) begin
      lat++;
      if (bx[i] == nx && by[i] == ny) begin hit = 1; break; end
    end
    if (hit) begin m_dead = 1; return; end
    if (!g) begin
      exp_q.push_back({X_W'(bx[bx.size()-1]), Y_W'(by[by.size()-1]), 3'b000});
      void'(bx.pop_back()); void'(by.pop_back());
      lat++;
    end
    exp_q.push_back({X_W'(nx), Y_W'(ny), 3'b010});
    bx.push_front(nx); by.push_front(ny);
    lat++;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 0; tick = 0; food_valid = 0; pix.pix_ready = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 resetn = 1;
  endtask

  task automatic compare_events(input string tag);
    total++;
    if (got_q.size() !== exp_q.size()) begin
      $display("FAIL %s pixel_count: got %0d required %0d", tag, got_q.size(), exp_q.size());
    end else begin
      passed++;
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (got_q[i] !== exp_q[i])
          $display("FAIL %s pixel[%0d]: got %h required %h", tag, i, got_q[i], exp_q[i]);
        else passed++;
      end
    end
  endtask

  task automatic do_step(input int d, input bit fv, input int fx, input int fy,
                         input bit rand_rdy, input string tag);
    bit g;
    int lat, cyc;
    model_step(d, fv, fx, fy, g, lat);
    got_q.delete(); ate_cnt = 0; stall_bad = 0; valid_cnt = 0;
    @(posedge clk); #1;
    dir_req = 2'(d); food_valid = fv; food_x = X_W'(fx); food_y = Y_W'(fy); tick = 1;
    @(posedge clk); #1;
    tick = 0; cyc = 0;
    while (busy && cyc < 400) begin
      cyc++;
      pix.pix_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge clk); #1;
    end
    pix.pix_ready = 1;
    total++; if (cyc >= 400) $display("FAIL %s step_timeout: got %0d cycles required <400", tag, cyc); else passed++;
    compare_events(tag);
    total++; if (ate_cnt !== int'(g)) $display("FAIL %s ate_pulses: got %0d required %0d", tag, ate_cnt, g); else passed++;
    total++; if (dead !== m_dead) $display("FAIL %s dead: got %b required %b", tag, dead, m_dead); else passed++;
    total++; if (length !== LW'(bx.size())) $display("FAIL %s length: got %0d required %0d", tag, length, bx.size()); else passed++;
    total++; if (stall_bad !== 0) $display("FAIL %s stall_hold: got %0d changes required 0", tag, stall_bad); else passed++;
    if (!rand_rdy) begin
      total++; if (cyc !== lat) $display("FAIL %s latency: got %0d required %0d", tag, cyc, lat); else passed++;
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    resetn = 0; pix.pix_ready = 1; model_reset();
    repeat (2) @(posedge clk); #1;
    total++;
    if ({pix.pix_valid, pix.pix_x, pix.pix_y, pix.pix_colour, ate, dead, busy} !== '0)
      $display("FAIL reset_outputs: got %b required 0", {pix.pix_valid, pix.pix_x, pix.pix_y, pix.pix_colour, ate, dead, busy});
    else passed++;
    total++; if (length !== LW'(1)) $display("FAIL reset_length: got %0d required 1", length); else passed++;
    resetn = 1;
  endtask

  task automatic test_first_step();
    do_reset();
    do_step(1, 0, 0, 0, 0, "first_step");
    total++;
    if (got_q.size() != 2 || got_q[0] !== {8'd10, 7'd60, 3'b000} || got_q[1] !== {8'd11, 7'd60, 3'b010})
      $display("FAIL first_step_pixels: got %0d pixels first %h required erase (10,60) draw (11,60)", got_q.size(), got_q.size() > 0 ? got_q[0] : ev_t'(0));
    else passed++;
  endtask

  task automatic test_reversal();
    do_step(0, 0, 0, 0, 0, "reversal");
    total++;
    if (got_q.size() == 0 || got_q[got_q.size()-1] !== {8'd12, 7'd60, 3'b010})
      $display("FAIL reversal_head: got %h required %h", got_q.size() > 0 ? got_q[got_q.size()-1] : ev_t'(0), {8'd12, 7'd60, 3'b010});
    else passed++;
  endtask

  task automatic test_grow();
    do_reset();
    do_step(1, 0, 0, 0, 0, "grow_pre");
    do_step(1, 1, 12, 60, 0, "grow");
    total++;
    if (got_q.size() != 1 || ate_cnt != 1 || length !== LW'(2))
      $display("FAIL grow_basic: got %0d pixels ate %0d length %0d required 1 pixel ate 1 length 2", got_q.size(), ate_cnt, length);
    else passed++;
  endtask

  task automatic test_stall();
    bit  g;
    int  lat, cyc, busy_seen;
    ev_t ev0;
    do_reset();
    model_step(1, 0, 0, 0, g, lat);
    got_q.delete(); stall_bad = 0; ate_cnt = 0;
    @(posedge clk); #1;
    pix.pix_ready = 0; dir_req = 1; food_valid = 0; tick = 1;
    @(posedge clk); #1;
    tick = 0; cyc = 0;
    while (!pix.pix_valid && cyc < 20) begin cyc++; @(posedge clk); #1; end
    ev0 = {pix.pix_x, pix.pix_y, pix.pix_colour};
    total++; if (ev0 !== {8'd10, 7'd60, 3'b000}) $display("FAIL stall_erase: got %h required %h", ev0, {8'd10, 7'd60, 3'b000}); else passed++;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (pix.pix_valid !== 1'b1 || {pix.pix_x, pix.pix_y, pix.pix_colour} !== ev0)
        $display("FAIL stall_hold_%0d: got valid %b data %h required valid 1 data %h", i, pix.pix_valid, {pix.pix_x, pix.pix_y, pix.pix_colour}, ev0);
      else passed++;
      tick = (i == 2);
      @(posedge clk); #1;
    end
    tick = 0; pix.pix_ready = 1; cyc = 0;
    while (busy && cyc < 20) begin cyc++; @(posedge clk); #1; end
    busy_seen = 0;
    repeat (4) begin if (busy) busy_seen++; @(posedge clk); #1; end
    compare_events("stall");
    total++; if (busy_seen !== 0) $display("FAIL stall_tick_dropped: got %0d busy cycles required 0", busy_seen); else passed++;
    total++; if (stall_bad !== 0) $display("FAIL stall_stable: got %0d changes required 0", stall_bad); else passed++;
    exp_q.delete();
  endtask

  task automatic test_reset_abort();
    int cyc;
    do_reset();
    @(posedge clk); #1;
    dir_req = 1; tick = 1;
    @(posedge clk); #1;
    tick = 0; cyc = 0;
    while (!pix.pix_valid && cyc < 20) begin cyc++; @(posedge clk); #1; end
    #2 resetn = 0;
    #1;
    total++;
    if ({pix.pix_valid, busy, dead} !== 3'b000 || length !== LW'(1))
      $display("FAIL reset_abort: got valid/busy/dead %b length %0d required 000 length 1", {pix.pix_valid, busy, dead}, length);
    else passed++;
    do_reset();
    do_step(1, 0, 0, 0, 0, "after_abort");
  endtask

  task automatic test_wall();
    do_reset();
    for (int i = 0; i < 149; i++) do_step(1, 0, 0, 0, (i % 2) == 1, "wall_walk");
    do_step(1, 0, 0, 0, 0, "wall");
`ifdef SNAKE_WALL_WRAP_EN
    total++;
    if (dead !== 1'b0 || got_q.size() != 2 || got_q[1] !== {8'd0, 7'd60, 3'b010})
      $display("FAIL wall_wrap: got dead %b pixels %0d required dead 0 draw (0,60)", dead, got_q.size());
    else passed++;
`else
    total++;
    if (dead !== 1'b1 || got_q.size() != 0)
      $display("FAIL wall_death: got dead %b pixels %0d required dead 1 pixels 0", dead, got_q.size());
    else passed++;
`endif
  endtask

  task automatic test_self_collision();
    do_reset();
    for (int i = 11; i <= 14; i++) do_step(1, 1, i, 60, 0, "body_grow");
    total++; if (length !== LW'(5)) $display("FAIL body_len: got %0d required 5", length); else passed++;
    do_step(2, 0, 0, 0, 0, "body_up");
    do_step(0, 0, 0, 0, 0, "body_left");
    do_step(3, 0, 0, 0, 0, "body_down");
    total++; if (dead !== 1'b1) $display("FAIL self_collision: got dead %b required 1", dead); else passed++;
    do_step(1, 0, 0, 0, 0, "dead_tick");
    do_step(2, 0, 0, 0, 0, "dead_tick");
    total++; if (valid_cnt !== 0) $display("FAIL dead_no_pixels: got %0d valid cycles required 0", valid_cnt); else passed++;
    do_reset();
    total++; if (length !== LW'(1) || dead !== 1'b0) $display("FAIL dead_reset: got length %0d dead %b required 1 0", length, dead); else passed++;
    do_step(1, 0, 0, 0, 0, "post_dead");
  endtask

  task automatic test_random();
    int d, fx, fy;
    bit fv;
    do_reset();
    for (int n = 0; n < 250; n++) begin
      d  = $urandom_range(0, 3);
      fv = ($urandom_range(0, 2) != 0);
      fx = bx[0] + int'($urandom_range(0, 2)) - 1;
      fy = by[0] + int'($urandom_range(0, 2)) - 1;
      if (fx < 0) fx = 0;
      if (fy < 0) fy = 0;
      do_step(d, fv, fx, fy, (n % 2) == 0, "random");
      if (m_dead) do_reset();
    end
  endtask

  initial begin
    pix.pix_ready = 1;
    test_reset();
    test_first_step();
    test_reversal();
    test_grow();
    test_stall();
    test_reset_abort();
    test_wall();
    test_self_collision();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
